// File: rtl/sdram_ctrl_if_gen_if.sv
// Host/SDRAM-FSM side signal bundle for the SDRAM control interface block.
// The master modport is the environment (host + SDRAM command FSM); the
// slave modport is the sdram_ctrl_if_gen block itself.
interface sdram_ctrl_if_gen_if #(
  parameter int ASIZE = 23,
  parameter int DW    = 4
);
  // Host command port and SDRAM FSM feedback
  logic [2:0]       CMD;
  logic [ASIZE-1:0] ADDR;
  logic             CM_ACK;
  logic             REF_ACK;

  // Registered command decode
  logic             NOP;
  logic             READA;
  logic             WRITEA;
  logic [ASIZE-1:0] SADDR;
  logic             CMD_ACK;

  // Power-up sequence
  logic             INIT_REQ;
  logic             INIT_PRECHARGE;
  logic             INIT_REFRESH;
  logic             INIT_LOAD_MODE;
  logic             INIT_DONE;

  // Periodic refresh scheduling
  logic             REF_REQ;
  logic             REF_URGENT;
  logic [DW-1:0]    REF_DEBT;
  logic             REF_OVF;

  modport master (
    output CMD, ADDR, CM_ACK, REF_ACK,
    input  NOP, READA, WRITEA, SADDR, CMD_ACK,
    input  INIT_REQ, INIT_PRECHARGE, INIT_REFRESH, INIT_LOAD_MODE, INIT_DONE,
    input  REF_REQ, REF_URGENT, REF_DEBT, REF_OVF
  );

  modport slave (
    input  CMD, ADDR, CM_ACK, REF_ACK,
    output NOP, READA, WRITEA, SADDR, CMD_ACK,
    output INIT_REQ, INIT_PRECHARGE, INIT_REFRESH, INIT_LOAD_MODE, INIT_DONE,
    output REF_REQ, REF_URGENT, REF_DEBT, REF_OVF
  );
endinterface

// File: rtl/sdram_ctrl_if_gen.sv
// SDRAM control interface: registers and decodes host commands, sequences
// the power-up commands (wait, PRECHARGE, N x REFRESH, LOAD_MODE) from one
// cycle counter, and schedules periodic refresh with a saturating debt
// counter, an urgency flag and a sticky overflow flag. Reads and writes are
// gated off until the power-up sequence has completed.
module sdram_ctrl_if_gen #(
  parameter int ASIZE          = 23,
  parameter int INIT_PER       = 24000,
  parameter int INIT_STEP      = 20,
  parameter int INIT_REFRESHES = 8,
  parameter int REF_PER        = 1024,
  parameter int MAX_DEBT       = 8,
  parameter int URGENT_THR     = 4,
  parameter int DW             = $clog2(MAX_DEBT + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  sdram_ctrl_if_gen_if.slave bus
);

  // Cycle (after reset release) of each init command
  localparam int PRE_CYCLE = INIT_PER + INIT_STEP;
  localparam int LMR_CYCLE = INIT_PER + (INIT_REFRESHES + 2) * INIT_STEP;
  // Counter must reach LMR_CYCLE
  localparam int CW        = $clog2(LMR_CYCLE + 1);
  // Refresh index must reach INIT_REFRESHES (all issued)
  localparam int KW        = $clog2(INIT_REFRESHES + 1);
  localparam int TW        = $clog2(REF_PER);

  typedef enum logic [2:0] {
    S_WAIT,  // power-up wait, PRECHARGE not yet issued
    S_PRE,   // PRECHARGE issued, waiting for first REFRESH
    S_REF,   // issuing the init REFRESH commands, then LOAD_MODE
    S_LMR,   // LOAD_MODE issued this cycle
    S_DONE   // sequence complete, counter frozen
  } init_state_t;

  // ---------------------------------------------------------------------
  // Command decode registers
  // ---------------------------------------------------------------------
  logic [ASIZE-1:0] saddr_q;
  logic             nop_q;
  logic             reada_q;
  logic             writea_q;
  logic             cmd_ack_q;

  // ---------------------------------------------------------------------
  // Init sequencer registers
  // ---------------------------------------------------------------------
  init_state_t      state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nxt;
  logic [KW-1:0]    ref_k_q;
  logic             init_req_q;
  logic             init_pre_q;
  logic             init_ref_q;
  logic             init_lmr_q;
  logic             init_done_q;

  // ---------------------------------------------------------------------
  // Refresh scheduler registers
  // ---------------------------------------------------------------------
  logic [TW-1:0]    timer_q;
  logic             tick;
  logic             ref_ack_ok;
  logic [DW-1:0]    debt_q;
  logic [DW-1:0]    debt_nxt;
  logic             ovf_set;
  logic             ovf_q;

  // Cycle at which the k-th init REFRESH is issued
  function automatic logic [CW-1:0] ref_cycle(input logic [KW-1:0] k);
    return CW'(INIT_PER + (int'(k) + 2) * INIT_STEP);
  endfunction

  assign cnt_nxt = cnt_q + CW'(1);

  // Register the host address and decode the command; reads and writes are
  // suppressed until init is done, CMD_ACK toggles while CM_ACK is held.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RESET) begin
      saddr_q   <= '0;
      nop_q     <= 1'b0;
      reada_q   <= 1'b0;
      writea_q  <= 1'b0;
      cmd_ack_q <= 1'b0;
    end else begin
      saddr_q   <= bus.ADDR;
      nop_q     <= (bus.CMD == 3'b000);
      reada_q   <= (bus.CMD == 3'b001) && init_done_q;
      writea_q  <= (bus.CMD == 3'b010) && init_done_q;
      cmd_ack_q <= bus.CM_ACK && !cmd_ack_q;
    end
  end

  // Power-up sequencer: one free-running counter compared against the
  // absolute cycle of each command; outputs are registered one-cycle pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      ref_k_q     <= '0;
      init_req_q  <= 1'b1;
      init_pre_q  <= 1'b0;
      init_ref_q  <= 1'b0;
      init_lmr_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      init_pre_q <= 1'b0;
      init_ref_q <= 1'b0;
      init_lmr_q <= 1'b0;
      unique case (state_q)
        S_WAIT: begin
          cnt_q      <= cnt_nxt;
          init_req_q <= (cnt_nxt < CW'(INIT_PER));
          if (cnt_nxt == CW'(PRE_CYCLE)) begin
            init_pre_q <= 1'b1;
            state_q    <= S_PRE;
          end
        end
        S_PRE: begin
          cnt_q <= cnt_nxt;
          if (cnt_nxt == ref_cycle('0)) begin
            init_ref_q <= 1'b1;
            ref_k_q    <= KW'(1);
            state_q    <= S_REF;
          end
        end
        S_REF: begin
          cnt_q <= cnt_nxt;
          if (ref_k_q == KW'(INIT_REFRESHES)) begin
            if (cnt_nxt == CW'(LMR_CYCLE)) begin
              init_lmr_q <= 1'b1;
              state_q    <= S_LMR;
            end
          end else if (cnt_nxt == ref_cycle(ref_k_q)) begin
            init_ref_q <= 1'b1;
            ref_k_q    <= ref_k_q + KW'(1);
          end
        end
        S_LMR: begin
          init_done_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_WAIT;
        end
      endcase
    end
  end

  // A tick is the last cycle of a refresh interval; acks count only once
  // the power-up sequence is complete.
  assign tick       = init_done_q && (timer_q == '0);
  assign ref_ack_ok = bus.REF_ACK && init_done_q;

  // Refresh interval timer: parked at full count until init completes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      timer_q <= TW'(REF_PER - 1);
    end else if (init_done_q) begin
      timer_q <= tick ? TW'(REF_PER - 1) : timer_q - TW'(1);
    end
  end

  // Next refresh debt: a tick adds one, an ack removes one, both cancel;
  // a tick at saturation is lost and flags overflow.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    debt_nxt = debt_q;
    ovf_set  = 1'b0;
    if (tick && !ref_ack_ok) begin
      if (debt_q == DW'(MAX_DEBT)) begin
        ovf_set = 1'b1;
      end else begin
        debt_nxt = debt_q + DW'(1);
      end
    end else if (ref_ack_ok && !tick && (debt_q != '0)) begin
      debt_nxt = debt_q - DW'(1);
    end
  end

  // Debt register and sticky overflow flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      debt_q <= debt_nxt;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // All outputs come straight from registers (request flags decode the
  // debt register only).
  assign bus.NOP            = nop_q;
  assign bus.READA          = reada_q;
  assign bus.WRITEA         = writea_q;
  assign bus.SADDR          = saddr_q;
  assign bus.CMD_ACK        = cmd_ack_q;
  assign bus.INIT_REQ       = init_req_q;
  assign bus.INIT_PRECHARGE = init_pre_q;
  assign bus.INIT_REFRESH   = init_ref_q;
  assign bus.INIT_LOAD_MODE = init_lmr_q;
  assign bus.INIT_DONE      = init_done_q;
  assign bus.REF_REQ        = (debt_q != '0);
  assign bus.REF_URGENT     = (debt_q >= DW'(URGENT_THR));
  assign bus.REF_DEBT       = debt_q;
  assign bus.REF_OVF        = ovf_q;

endmodule

// File: tb/tb_sdram_ctrl_if_gen.sv
// Directed bench for sdram_ctrl_if_gen with short timing parameters.
// A table of {cycle, inputs, expected outputs} drives the main scenario;
// hand-written sequences cover CMD_ACK toggling and asynchronous reset.
module tb_sdram_ctrl_if_gen;

  localparam int ASIZE = 23;
  localparam int DW    = 2;

  typedef struct packed {
    logic             nop;
    logic             reada;
    logic             writea;
    logic [ASIZE-1:0] saddr;
    logic             cmd_ack;
    logic             init_req;
    logic             pre;
    logic             rf;
    logic             lmr;
    logic             done;
    logic             ref_req;
    logic             urgent;
    logic [DW-1:0]    debt;
    logic             ovf;
  } outs_t;

  typedef struct {
    int               cyc;
    logic [2:0]       cmd;
    logic [ASIZE-1:0] addr;
    logic             cm_ack;
    logic             ref_ack;
    outs_t            exp;
  } vec_t;

  logic CLK;
  logic RESET;
  int   cyc;
  int   n_vec;
  int   n_fail;
  vec_t vecs[$];

  sdram_ctrl_if_gen_if #(.ASIZE(ASIZE), .DW(DW)) bif ();

  sdram_ctrl_if_gen #(
    .ASIZE(ASIZE), .INIT_PER(50), .INIT_STEP(4), .INIT_REFRESHES(2),
    .REF_PER(16), .MAX_DEBT(3), .URGENT_THR(2)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic outs_t mk(input logic nop, input logic rd, input logic wr,
                               input logic [ASIZE-1:0] sa, input logic cack,
                               input logic req, input logic pre, input logic rf,
                               input logic lmr, input logic done, input logic rreq,
                               input logic urg, input logic [DW-1:0] debt,
                               input logic ovf);
    outs_t o;
    o = '{nop, rd, wr, sa, cack, req, pre, rf, lmr, done, rreq, urg, debt, ovf};
    return o;
  endfunction

  function automatic outs_t sample();
    return mk(bif.NOP, bif.READA, bif.WRITEA, bif.SADDR, bif.CMD_ACK,
              bif.INIT_REQ, bif.INIT_PRECHARGE, bif.INIT_REFRESH,
              bif.INIT_LOAD_MODE, bif.INIT_DONE, bif.REF_REQ, bif.REF_URGENT,
              bif.REF_DEBT, bif.REF_OVF);
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("nop=%0b rd=%0b wr=%0b saddr=%h cack=%0b req=%0b pre=%0b ref=%0b lmr=%0b done=%0b rreq=%0b urg=%0b debt=%0d ovf=%0b",
                     o.nop, o.reada, o.writea, o.saddr, o.cmd_ack, o.init_req,
                     o.pre, o.rf, o.lmr, o.done, o.ref_req, o.urgent, o.debt, o.ovf);
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t got;
    got = sample();
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got {%s} expected {%s}", name, cyc, fmt(got), fmt(exp));
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [2:0] cmd, input logic [ASIZE-1:0] addr,
                       input logic cm_ack, input logic ref_ack);
    bif.CMD     = cmd;
    bif.ADDR    = addr;
    bif.CM_ACK  = cm_ack;
    bif.REF_ACK = ref_ack;
  endtask

  task automatic add(input int c, input logic [2:0] cmd, input logic [ASIZE-1:0] addr,
                     input logic cm, input logic ra, input outs_t e);
    vecs.push_back('{c, cmd, addr, cm, ra, e});
  endtask

  // Release reset just after a rising edge; the following edge is cycle 1.
  task automatic release_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc   = 0;
  endtask

  outs_t rst_vals;

  initial begin
    n_vec  = 0;
    n_fail = 0;
    cyc    = 0;
    RESET  = 1'b1;
    drive(3'b111, '0, 1'b0, 1'b0);
    rst_vals = mk(0,0,0,'0,0, 1,0,0,0,0, 0,0,2'd0,0);

    //   cycle cmd     addr        cm ra  nop rd wr saddr      ck rq pr rf lm dn rr ug debt ovf
    add(  0, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h0,     0,1,0,0,0,0,0,0,2'd0,0));
    add(  1, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h55,    0,1,0,0,0,0,0,0,2'd0,0));
    add( 49, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h55,    0,1,0,0,0,0,0,0,2'd0,0));
    add( 50, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h55,    0,0,0,0,0,0,0,0,2'd0,0));
    add( 53, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h55,    0,0,0,0,0,0,0,0,2'd0,0));
    add( 54, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h55,    0,0,1,0,0,0,0,0,2'd0,0));
    add( 55, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h55,    0,0,0,0,0,0,0,0,2'd0,0));
    add( 58, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h55,    0,0,0,1,0,0,0,0,2'd0,0));
    add( 59, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h55,    0,0,0,0,0,0,0,0,2'd0,0));
    add( 62, 3'b001, 23'h55,     0, 0, mk(0,0,0,23'h55,    0,0,0,1,0,0,0,0,2'd0,0));
    add( 66, 3'b010, 23'h1234,   0, 0, mk(0,0,0,23'h55,    0,0,0,0,1,0,0,0,2'd0,0));
    add( 67, 3'b010, 23'h1234,   0, 0, mk(0,0,0,23'h1234,  0,0,0,0,0,1,0,0,2'd0,0));
    add( 68, 3'b000, 23'h0,      0, 0, mk(0,0,1,23'h1234,  0,0,0,0,0,1,0,0,2'd0,0));
    add( 69, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,0,0,2'd0,0));
    add( 82, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,0,0,2'd0,0));
    add( 83, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,0,2'd1,0));
    add( 98, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,0,2'd1,0));
    add( 99, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,1,2'd2,0));
    add(115, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,1,2'd3,0));
    add(130, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,1,2'd3,0));
    add(131, 3'b000, 23'h0,      0, 1, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,1,2'd3,1));
    add(132, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,1,2'd2,1));
    add(146, 3'b000, 23'h0,      0, 1, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,1,2'd2,1));
    add(147, 3'b000, 23'h0,      0, 1, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,1,2'd2,1));
    add(148, 3'b000, 23'h0,      0, 1, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,0,2'd1,1));
    add(149, 3'b000, 23'h0,      0, 1, mk(1,0,0,23'h0,     0,0,0,0,0,1,0,0,2'd0,1));
    add(150, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,0,0,2'd0,1));
    add(162, 3'b000, 23'h0,      0, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,0,0,2'd0,1));
    add(163, 3'b000, 23'h0,      1, 0, mk(1,0,0,23'h0,     0,0,0,0,0,1,1,0,2'd1,1));

    repeat (3) @(posedge CLK);
    release_reset();

    // Main table: advance to each vector's cycle, compare, then apply its inputs.
    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) step();
      check($sformatf("vec%0d", i), vecs[i].exp);
      drive(vecs[i].cmd, vecs[i].addr, vecs[i].cm_ack, vecs[i].ref_ack);
    end

    // CM_ACK held for four edges (raised by the last vector): 1,0,1,0.
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("cmd_ack_%0d", k),
            mk(1,0,0,23'h0, ((k % 2) == 0) ? 1'b1 : 1'b0, 0,0,0,0,1,1,0,2'd1,1));
    end
    drive(3'b000, '0, 1'b0, 1'b0);
    step();
    check("cmd_ack_off", mk(1,0,0,23'h0, 0,0,0,0,0,1,1,0,2'd1,1));

    // Reset with debt and overflow outstanding clears everything at once.
    drive(3'b111, '0, 1'b0, 1'b0);
    RESET = 1'b1;
    #1;
    check("reset_mid_debt", rst_vals);
    step();
    step();
    check("reset_mid_debt_held", rst_vals);
    release_reset();
    check("reset_release_c0", rst_vals);

    // Reset mid-init at cycle 60 for 3 cycles, then the sequence reruns.
    while (cyc < 60) step();
    check("pre_reset_c60", mk(0,0,0,23'h0, 0,0,0,0,0,0,0,0,2'd0,0));
    RESET = 1'b1;
    #1;
    check("reset_mid_init", rst_vals);
    step();
    step();
    check("reset_mid_init_held", rst_vals);
    release_reset();
    while (cyc < 53) step();
    check("rerun_c53", mk(0,0,0,23'h0, 0,0,0,0,0,0,0,0,2'd0,0));
    step();
    check("rerun_pre_c54", mk(0,0,0,23'h0, 0,0,1,0,0,0,0,0,2'd0,0));
    step();
    check("rerun_c55", mk(0,0,0,23'h0, 0,0,0,0,0,0,0,0,2'd0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
